// File: rtl/nioslab2_onchip_mem_arbiter_pkg.sv
// Shared types and widths for the on-chip RAM arbiter and its round-robin core.
package niosLab2_mem_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  // Identifies which master issued an access: 0 = Nios data master, 1 = DMA master.
  typedef logic master_id_t;

  // One slot of the read-return pipeline.
  typedef struct packed {
    logic       valid;
    master_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/nioslab2_onchip_mem_arbiter_rr_arb2.sv
// Two-request round-robin arbiter. The grant is combinational, and the register
// remembers which master was served last. When both masters request, the other
// master wins.
module niosLab2_rr_arb2
  import niosLab2_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  master_id_t lastGrant_q;
  master_id_t lastGrant_d;

  // Pick the winner for this cycle. The last-grant record only moves on cycles
  // that actually hand out a grant.
  always_comb begin
    grant_o     = 2'b00;
    lastGrant_d = lastGrant_q;
    if (req_i[0] && (!req_i[1] || (lastGrant_q == 1'b1))) begin
      grant_o = 2'b01;
    end else if (req_i[1]) begin
      grant_o = 2'b10;
    end
    if (advance_i && (grant_o != 2'b00)) begin
      lastGrant_d = grant_o[1];
    end
  end

  // Reset to "m1 served last" so the first conflict after reset goes to m0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lastGrant_q <= 1'b1;
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end

endmodule

// File: rtl/nioslab2_onchip_mem_arbiter.sv
// Shares the single-port on-chip RAM between the Nios data master (m0) and the
// DMA master (m1). It issues one access per cycle and steers read data back to
// the master that issued the read.
module nioslab2_onchip_mem_arbiter
  import niosLab2_mem_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic [1:0] req;
  logic [1:0] grant;
  logic       grantRead;
  master_id_t grantId;
  rd_tag_t    tagOut;

  rd_tag_t [RD_LATENCY-1:0] tag_q;
  rd_tag_t [RD_LATENCY-1:0] tag_d;

  // While in reset no master may request. This keeps both waitrequests high and the RAM idle.
  assign req = {(m1_read | m1_write), (m0_read | m0_write)} & {2{reset_n}};

  niosLab2_rr_arb2 uArb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     (req),
    .advance_i (reset_n),
    .grant_o   (grant)
  );

  assign m0_waitrequest = ~grant[0];
  assign m1_waitrequest = ~grant[1];
  assign mem_clken      = reset_n;

  // Steer the granted master onto the RAM port. With no grant, m0 is selected as a don't-care.
  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    mem_write      = 1'b0;
    mem_chipselect = 1'b0;
    if (grant[1]) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
      mem_chipselect = 1'b1;
    end else if (grant[0]) begin
      mem_write      = m0_write;
      mem_chipselect = 1'b1;
    end
  end

  // A granted access with write low is a read. If write and read are both high, write wins.
  assign grantRead = mem_chipselect & ~mem_write;
  assign grantId   = grant[1];

  // Next state of the read-tag shift line. Slot 0 takes a new read, and older slots move down one.
  always_comb begin
    tag_d          = '0;
    tag_d[0].valid = grantRead;
    tag_d[0].id    = grantId;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Tag register. Reset discards reads in flight, so they never report valid data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  // The oldest tag lines up with the RAM's readdata for that read.
  assign tagOut           = tag_q[RD_LATENCY-1];
  assign m0_readdatavalid = tagOut.valid & (tagOut.id == 1'b0) & reset_n;
  assign m1_readdatavalid = tagOut.valid & (tagOut.id == 1'b1) & reset_n;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_nioslab2_onchip_mem_arbiter.sv
// Bench for the on-chip RAM arbiter. Two builds run side by side (read latency 1 and 2).
// They share the master stimulus, and each has its own behavioural RAM. A reference
// model predicts grants and read data, and queues each expected read return.
module tb_nioslab2_onchip_mem_arbiter;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        reset_n;
  int          cyc;
  int          totalChecks;
  int          badChecks;

  logic [16:0] m0Address, m1Address;
  logic [3:0]  m0Byteenable, m1Byteenable;
  logic        m0Read, m0Write, m1Read, m1Write;
  logic [31:0] m0Writedata, m1Writedata;

  logic        m0WaitA, m1WaitA, m0RdvA, m1RdvA, memCsA, memWrA, memClkenA;
  logic [31:0] m0RdataA, m1RdataA, memWdataA, memRdA;
  logic [16:0] memAddrA;
  logic [3:0]  memBeA;
  logic        m0WaitB, m1WaitB, m0RdvB, m1RdvB, memCsB, memWrB, memClkenB;
  logic [31:0] m0RdataB, m1RdataB, memWdataB, memRdB, rdB1;
  logic [16:0] memAddrB;
  logic [3:0]  memBeB;

  logic [31:0] ramA   [0:131071];
  logic [31:0] ramB   [0:131071];
  logic [31:0] refMem [0:131071];

  exp_t qA[$];
  exp_t qB[$];
  logic lastGrantM;

  nioslab2_onchip_mem_arbiter #(.RD_LATENCY(1)) dutA (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0Address), .m0_byteenable(m0Byteenable), .m0_read(m0Read),
    .m0_write(m0Write), .m0_writedata(m0Writedata), .m0_waitrequest(m0WaitA),
    .m0_readdata(m0RdataA), .m0_readdatavalid(m0RdvA),
    .m1_address(m1Address), .m1_byteenable(m1Byteenable), .m1_read(m1Read),
    .m1_write(m1Write), .m1_writedata(m1Writedata), .m1_waitrequest(m1WaitA),
    .m1_readdata(m1RdataA), .m1_readdatavalid(m1RdvA),
    .mem_address(memAddrA), .mem_byteenable(memBeA), .mem_chipselect(memCsA),
    .mem_write(memWrA), .mem_writedata(memWdataA), .mem_clken(memClkenA),
    .mem_readdata(memRdA)
  );

  nioslab2_onchip_mem_arbiter #(.RD_LATENCY(2)) dutB (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0Address), .m0_byteenable(m0Byteenable), .m0_read(m0Read),
    .m0_write(m0Write), .m0_writedata(m0Writedata), .m0_waitrequest(m0WaitB),
    .m0_readdata(m0RdataB), .m0_readdatavalid(m0RdvB),
    .m1_address(m1Address), .m1_byteenable(m1Byteenable), .m1_read(m1Read),
    .m1_write(m1Write), .m1_writedata(m1Writedata), .m1_waitrequest(m1WaitB),
    .m1_readdata(m1RdataB), .m1_readdatavalid(m1RdvB),
    .mem_address(memAddrB), .mem_byteenable(memBeB), .mem_chipselect(memCsB),
    .mem_write(memWrB), .mem_writedata(memWdataB), .mem_clken(memClkenB),
    .mem_readdata(memRdB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number, stable between posedges
  always @(posedge clk) cyc <= cyc + 1;

  // Latency-1 RAM for build A
  always @(posedge clk) begin
    if (memClkenA && memCsA) begin
      if (memWrA) begin
        for (int b = 0; b < 4; b++)
          if (memBeA[b]) ramA[memAddrA][8*b +: 8] <= memWdataA[8*b +: 8];
      end else begin
        memRdA <= ramA[memAddrA];
      end
    end
  end

  // Latency-2 RAM for build B: one extra output register
  always @(posedge clk) begin
    if (memClkenB) begin
      memRdB <= rdB1;
      if (memCsB) begin
        if (memWrB) begin
          for (int b = 0; b < 4; b++)
            if (memBeB[b]) ramB[memAddrB][8*b +: 8] <= memWdataB[8*b +: 8];
        end else begin
          rdB1 <= ramB[memAddrB];
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, wanted %0h", tag, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [16:0] a0,
                               input logic [3:0] be0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [16:0] a1,
                               input logic [3:0] be1, input logic [31:0] d1);
    m0Read = r0; m0Write = w0; m0Address = a0; m0Byteenable = be0; m0Writedata = d0;
    m1Read = r1; m1Write = w1; m1Address = a1; m1Byteenable = be1; m1Writedata = d1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 4'hF, 0, 0, 0, 0, 4'hF, 0);
  endtask

  task automatic preload(input logic [16:0] a, input logic [31:0] d);
    ramA[a] = d; ramB[a] = d; refMem[a] = d;
  endtask

  // Reference model and scoreboard, sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    logic req0, req1, g0, g1, expV, expId;
    logic [31:0] expData;
    logic [16:0] gAddr;
    if (!reset_n) begin
      qA.delete();
      qB.delete();
      lastGrantM = 1'b1;
      checkOutput("wait0A", m0WaitA, 1);
      checkOutput("wait1A", m1WaitA, 1);
      checkOutput("wait0B", m0WaitB, 1);
      checkOutput("csA", memCsA, 0);
      checkOutput("wrA", memWrA, 0);
      checkOutput("clkenA", memClkenA, 0);
      checkOutput("rstRdvA", {m0RdvA, m1RdvA}, 0);
      checkOutput("rstRdvB", {m0RdvB, m1RdvB}, 0);
    end else begin
      // Read returns for build A
      expV = (qA.size() > 0) && (qA[0].due == cyc);
      expId = expV ? qA[0].id : 1'b0;
      expData = expV ? qA[0].data : 32'h0;
      checkOutput("rdv0A", m0RdvA, expV && !expId);
      checkOutput("rdv1A", m1RdvA, expV && expId);
      if (expV) begin
        checkOutput("rdataA", expId ? m1RdataA : m0RdataA, expData);
        void'(qA.pop_front());
      end
      // Read returns for build B
      expV = (qB.size() > 0) && (qB[0].due == cyc);
      expId = expV ? qB[0].id : 1'b0;
      expData = expV ? qB[0].data : 32'h0;
      checkOutput("rdv0B", m0RdvB, expV && !expId);
      checkOutput("rdv1B", m1RdvB, expV && expId);
      if (expV) begin
        checkOutput("rdataB", expId ? m1RdataB : m0RdataB, expData);
        void'(qB.pop_front());
      end
      // Arbitration
      req0 = m0Read | m0Write;
      req1 = m1Read | m1Write;
      g0 = req0 && (!req1 || lastGrantM);
      g1 = req1 && (!req0 || !lastGrantM);
      checkOutput("wait0A", m0WaitA, !g0);
      checkOutput("wait1A", m1WaitA, !g1);
      checkOutput("wait0B", m0WaitB, !g0);
      checkOutput("wait1B", m1WaitB, !g1);
      checkOutput("csA", memCsA, g0 | g1);
      checkOutput("clkenA", memClkenA, 1);
      if (g0 || g1) begin
        gAddr = g1 ? m1Address : m0Address;
        checkOutput("memAddrA", memAddrA, gAddr);
        checkOutput("wrA", memWrA, g1 ? m1Write : m0Write);
        if (g1 ? m1Write : m0Write) begin
          for (int b = 0; b < 4; b++) begin
            if ((g1 ? m1Byteenable[b] : m0Byteenable[b]))
              refMem[gAddr][8*b +: 8] = g1 ? m1Writedata[8*b +: 8] : m0Writedata[8*b +: 8];
          end
        end else begin
          qA.push_back('{id: g1, data: refMem[gAddr], due: cyc + 1});
          qB.push_back('{id: g1, data: refMem[gAddr], due: cyc + 2});
        end
        lastGrantM = g1;
      end else begin
        checkOutput("wrA", memWrA, 0);
      end
    end
  end

  initial begin
    cyc = 0;
    totalChecks = 0;
    badChecks = 0;
    lastGrantM = 1'b1;
    rdB1 = 32'h0;
    memRdA = 32'h0;
    memRdB = 32'h0;
    preload(17'h00010, 32'hDEADBEEF);
    preload(17'h1FFFF, 32'hAAAAAAAA);
    preload(17'h00020, 32'h0BADF00D);
    for (int i = 0; i < 8; i++) begin
      preload(17'h00100 + 17'(i), 32'h10000000 + 32'(i) * 32'h01010101);
      preload(17'h00200 + 17'(i), 32'h20000000 + 32'(i) * 32'h00110011);
      preload(17'h00300 + 17'(i), 32'h30000000 + 32'(i));
    end

    // Reset with requests pending: everything must stay stalled
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 17'h10, 4'hF, 0, 1, 0, 17'h10, 4'hF, 0);
    reset_n = 1'b1;

    // Continuous conflict right after reset: m0, m1, m0, ...
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 0, 17'h100 + 17'(i), 4'hF, 0, 1, 0, 17'h200 + 17'(i), 4'hF, 0);
    idle(3);

    // Single read by m0
    applyStimulus(1, 0, 17'h00010, 4'hF, 0, 0, 0, 0, 4'hF, 0);
    idle(3);

    // Partial-byte write by m1, then m0 reads it back on the next cycle
    applyStimulus(0, 0, 0, 4'hF, 0, 0, 1, 17'h1FFFF, 4'b0101, 32'h11223344);
    applyStimulus(1, 0, 17'h1FFFF, 4'hF, 0, 0, 0, 0, 4'hF, 0);
    idle(3);

    // Read and write together on m0: the write wins, so no read returns
    applyStimulus(1, 1, 17'h00020, 4'hF, 32'h55667788, 0, 0, 0, 4'hF, 0);
    applyStimulus(1, 0, 17'h00020, 4'hF, 0, 0, 0, 0, 4'hF, 0);
    idle(3);

    // Four back-to-back alternating reads
    applyStimulus(1, 0, 17'h101, 4'hF, 0, 0, 0, 0, 4'hF, 0);
    applyStimulus(0, 0, 0, 4'hF, 0, 1, 0, 17'h202, 4'hF, 0);
    applyStimulus(1, 0, 17'h103, 4'hF, 0, 0, 0, 0, 4'hF, 0);
    applyStimulus(0, 0, 0, 4'hF, 0, 1, 0, 17'h204, 4'hF, 0);
    idle(3);

    // m1 read in flight, then reset: the read never returns, and m0 wins the first conflict
    applyStimulus(0, 0, 0, 4'hF, 0, 1, 0, 17'h205, 4'hF, 0);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    applyStimulus(1, 0, 17'h106, 4'hF, 0, 1, 0, 17'h206, 4'hF, 0);
    idle(3);

    // m0 served last before reset: reset must hand the next conflict back to m0
    applyStimulus(1, 0, 17'h107, 4'hF, 0, 0, 0, 0, 4'hF, 0);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    applyStimulus(1, 0, 17'h100, 4'hF, 0, 1, 0, 17'h207, 4'hF, 0);
    applyStimulus(1, 0, 17'h101, 4'hF, 0, 1, 0, 17'h201, 4'hF, 0);
    idle(3);

    // Random mix of reads and writes over a small address window
    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom_range(0, 1), ($urandom_range(0, 3) == 0), 17'h300 + 17'($urandom_range(0, 7)),
                    4'($urandom), $urandom,
                    $urandom_range(0, 1), ($urandom_range(0, 3) == 0), 17'h300 + 17'($urandom_range(0, 7)),
                    4'($urandom), $urandom);
    end
    idle(4);

    checkOutput("drainA", qA.size(), 0);
    checkOutput("drainB", qB.size(), 0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/nioslab2_onchip_mem_arbiter.md
Name: niosLab2_onchip_mem_arbiter

Overview:
- Two-master round-robin arbiter that shares the single-port on-chip RAM (32-bit data, 17-bit word address, byte enables, read latency 1) between the Nios data master (m0) and a DMA/bulk-fill master (m1).
- Sits between the interconnect and the RAM slave port.
- Issues at most one access per cycle and holds non-granted masters with waitrequest.
- Tracks in-flight reads and returns each readdata, with readdatavalid, to the master that issued the read.

Parameters:
- ADDR_W, 17, word address width of the RAM port
- DATA_W, 32, data width
- BE_W, 4, byte-enable width (DATA_W/8)
- RD_LATENCY, 1, RAM cycles from address to readdata; legal values 1 or 2

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- m0_address  in  ADDR_W  master 0 word address
- m0_byteenable  in  BE_W  master 0 byte enables
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  DATA_W  master 0 read data
- m0_readdatavalid  out  1  master 0 read data qualifier
- m1_*  (same nine signals as m0_*)  master 1
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  BE_W  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  to RAM clken
- mem_readdata  in  DATA_W  from RAM readdata

Behaviour:
- Request: req_i = mi_read | mi_write. If both read and write are high, write wins and the read is ignored (protocol error).
- Grant is combinational in the same cycle:
  - If only one master requests, it is granted.
  - If both request, grant goes to the master not granted most recently (register last_grant).
- last_grant updates only on cycles where a grant occurs. Reset value of last_grant is 1, so m0 wins the first conflict.
- Waitrequest: mi_waitrequest = ~grant_i, so it is 1 when idle or losing. A granted access completes in that cycle, with zero added latency.
- Memory drive:
  - mem_chipselect = any grant.
  - mem_address, mem_byteenable and mem_writedata are muxed from the granted master.
  - mem_write = granted master's write.
  - When there is no grant, the address/byteenable/writedata mux selects m0 (don't-care) and chipselect/write are 0.
- mem_clken is tied to 1 while reset_n=1. It is 0 during reset.
- Read tracking:
  - A shift register RD_LATENCY deep holds {valid, master_id}.
  - Entry 0 is loaded on a granted read; all entries shift every cycle.
  - Output stage: mi_readdatavalid = valid & (id==i); mi_readdata = mem_readdata (broadcast, qualified only by valid).
  - Back-to-back reads (either master, any interleave) are fully pipelined: one result per cycle, in issue order.
- Writes produce no response. A write followed by a read to the same address on the next cycle returns the new data, since the RAM commits the write at the clock edge.
- Reset, applied synchronously when reset_n=0:
  - All shift-register valids are cleared.
  - last_grant <= 1.
  - Both waitrequests are held at 1.
  - mem_chipselect and mem_write are 0.
  - Reads in flight when reset asserts are dropped and never return a readdatavalid.
- Outputs while reset_n=0: waitrequest=1, readdatavalid=0, readdata=mem_readdata (don't-care), mem_chipselect=0, mem_write=0, mem_clken=0.
- Starvation bound: with both masters requesting continuously, grants alternate m0, m1, m0, ... and no master waits more than 1 cycle.

Decomposition:
- Shared package niosLab2_mem_pkg holds:
  - ADDR_W/DATA_W/BE_W constants
  - master id typedef (1 bit)
  - rd_tag_t struct {valid, id}
- One natural sub-module, niosLab2_rr_arb2: 2-request round-robin grant with last_grant register, inputs req[1:0], advance; output grant[1:0] one-hot.
- The read-tag pipeline stays inline in the top module.

Test Plan:
- Single reads: m0 reads addr 0x00010 (RAM preloaded 0xDEADBEEF) → m0_waitrequest=0 same cycle; m0_readdatavalid=1 with 0xDEADBEEF one cycle later; m1 sees no valid.
- Conflict fairness: both masters read continuously for 6 cycles after reset → grants m0,m1,m0,m1,m0,m1; each readdatavalid arrives tagged to the correct master with its data.
- Byte write: m1 writes 0x11223344 to 0x1FFFF with byteenable=4'b0101 over 0xAAAAAAAA, then m0 reads 0x1FFFF next cycle → m0 gets 0xAA22AA44.
- Read+write asserted together on m0 → write performed, no readdatavalid generated.
- Reset mid-flight: m1 read granted, reset_n=0 on the following cycle → no m1_readdatavalid; after release, first conflict is granted to m0.
- RD_LATENCY=2 build: 4 back-to-back alternating reads → four valids, each exactly 2 cycles after its grant, in issue order.
